// File: rtl/rx_pkg.sv
// Shared types for the UART receive sample controller.
//   rx_state_t : sample controller FSM states
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    RECEIVE   = 3'd2,
    STOP_WAIT = 3'd3,
    STOP_CHK  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/start_bit_det.sv
// Line synchronizer and start-edge detector.
//   clk                 : system clock
//   n_rst               : synchronous active-low reset
//   serial_in           : asynchronous UART line, idle high
//   serial_sync         : serial_in through two flops
//   new_packet_detected : 1->0 transition seen on the synchronized line
module start_bit_det (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  output logic serial_sync,
  output logic new_packet_detected
);

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  logic [2:0] sync_q;
  // vld_pipe[i] marks sync_q[i] as a real line sample rather than the reset
  // value. Without it, a line held low through reset would look like a 1->0
  // edge as the reset ones drain out of the chain.
  logic [2:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q   <= '1;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[1:0], serial_in};
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  assign serial_sync         = sync_q[1];
  assign new_packet_detected = vld_pipe[2] & sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/rx_sample_ctrl.sv
// UART receive sample controller: finds the start bit, checks it at half a
// bit period, then strobes an external shift register at the middle of each
// following bit and validates the stop bit.
//   clk           : system clock
//   n_rst         : synchronous active-low reset
//   serial_in     : asynchronous UART line, idle high
//   stop_bit      : stop bit from the downstream shift register
//   serial_sync   : synchronized line, shift register serial input
//   shift_strobe  : one-cycle pulse at mid-bit, shift register enable
//   load_buffer   : one-cycle pulse, valid frame ready
//   framing_error : last frame had a 0 stop bit; held until next start
//   busy          : controller not idle
module rx_sample_ctrl
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BITS     = 9
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic serial_sync,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(NUM_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] NB_LAST   = BIT_W'(NUM_BITS - 1);

  logic new_packet_detected;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             ferr_q, ferr_d;

  start_bit_det u_start_bit_det (
    .clk                 (clk),
    .n_rst               (n_rst),
    .serial_in           (serial_in),
    .serial_sync         (serial_sync),
    .new_packet_detected (new_packet_detected)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    ferr_d       = ferr_q;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (new_packet_detected) begin
          state_d = START;
          cnt_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a high line means a glitch
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!serial_sync) begin
            state_d = RECEIVE;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECEIVE: begin
        // Entered at mid start bit, so the counter's terminal value lands
        // at mid data bit
        if (cnt_q == BIT_LAST) begin
          shift_strobe = 1'b1;
          cnt_d        = '0;
          bit_d        = bit_q + 1'b1;
          if (bit_q == NB_LAST) state_d = STOP_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP_WAIT: begin
        // Give the shift register one cycle to present the stop bit
        state_d = STOP_CHK;
      end
      STOP_CHK: begin
        load_buffer = stop_bit;
        ferr_d      = ~stop_bit;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rx_sample_ctrl.sv
module tb_rx_sample_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial_in = 1'b1;
  logic stop_bit;
  logic serial_sync, shift_strobe, load_buffer, framing_error, busy;

  rx_sample_ctrl #(.CLKS_PER_BIT(10), .NUM_BITS(9)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .stop_bit      (stop_bit),
    .serial_sync   (serial_sync),
    .shift_strobe  (shift_strobe),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // cycle index, line history and cycles since reset release
  int         cyc = 0;
  logic [1:0] in_hist = 2'b11;
  int         rst_age = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    in_hist <= {in_hist[0], serial_in};
    rst_age <= n_rst ? rst_age + 1 : 0;
  end

  // monitor plus model of the downstream 9-bit shift register (LSB first)
  logic [8:0] sr = '0;
  assign stop_bit = sr[8];

  int         strobe_cnt = 0;
  int         load_cnt = 0;
  bit         busy_seen = 0;
  int         overlap_cnt = 0;
  int         sync_err = 0;
  int         strobe_cyc[$];
  int         load_cyc[$];
  logic [7:0] load_data[$];

  always @(negedge clk) begin
    if (shift_strobe && load_buffer) overlap_cnt++;
    if (rst_age >= 3 && serial_sync !== in_hist[1]) sync_err++;
    if (busy) busy_seen = 1;
    if (load_buffer) begin
      load_cnt++;
      load_cyc.push_back(cyc);
      load_data.push_back(sr[7:0]);
    end
    if (shift_strobe) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      sr = {serial_sync, sr[8:1]};
    end
  end

  task automatic clear_mon();
    strobe_cnt = 0;
    load_cnt   = 0;
    busy_seen  = 0;
    strobe_cyc.delete();
    load_cyc.delete();
    load_data.delete();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; drives start, 8 data bits LSB first, stop bit,
  // each 10 clocks. Leaves the stop level on the line. m is the cycle of the
  // falling drive, fm the framing_error seen mid start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            output int m, output logic fm);
    m = cyc;
    serial_in = 1'b0;
    repeat (5) @(negedge clk);
    fm = framing_error;
    repeat (5) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      serial_in = d[b];
      repeat (10) @(negedge clk);
    end
    serial_in = stop;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int m);
    int bad;
    bad = 0;
    check({tag, "_strobes"}, strobe_cnt, 9);
    check({tag, "_first_strobe"}, (strobe_cyc.size() > 0) ? strobe_cyc[0] - m : -1, 17);
    for (int k = 1; k < strobe_cyc.size(); k++)
      if (strobe_cyc[k] - strobe_cyc[k-1] != 10) bad++;
    check({tag, "_spacing"}, bad, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_load;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   m, m2;
    logic fm;
    bit   got4;

    vecs[0] = '{8'h55, 1'b1, 1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 0, 1'b1};
    vecs[2] = '{8'hA3, 1'b1, 1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", shift_strobe, 0);
    check("rst_load", load_buffer, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_busy", busy, 0);
    check("rst_sync", serial_sync, 1);

    // line low through and after reset: no start
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    n_rst = 1'b1;
    repeat (50) @(negedge clk);
    check("low_after_rst_busy", busy_seen, 0);
    check("low_after_rst_strobes", strobe_cnt, 0);
    serial_in = 1'b1;
    repeat (5) @(negedge clk);

    // table of single frames
    for (int i = 0; i < 6; i++) begin
      if (i > 0) check("ferr_hold", framing_error, vecs[i-1].exp_ferr);
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop, m, fm);
      serial_in = 1'b1;
      repeat (4) @(negedge clk);
      check_frame("vec", m);
      check("vec_loads", load_cnt, vecs[i].exp_load);
      if (vecs[i].exp_load == 1 && load_data.size() > 0 && strobe_cyc.size() >= 9) begin
        check("vec_data", load_data[0], vecs[i].data);
        check("vec_load_delay", load_cyc[0] - strobe_cyc[8], 2);
      end
      check("vec_ferr_mid", fm, 0);
      check("vec_ferr", framing_error, vecs[i].exp_ferr);
      check("vec_busy_idle", busy, 0);
    end

    // 3-cycle glitch: aborted at half-bit check
    clear_mon();
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_started", busy_seen, 1);
    check("glitch_strobes", strobe_cnt, 0);
    check("glitch_loads", load_cnt, 0);
    check("glitch_busy", busy, 0);
    check("glitch_ferr", framing_error, 0);

    // back-to-back frames
    clear_mon();
    send_frame(8'h3C, 1'b1, m, fm);
    send_frame(8'hC3, 1'b1, m2, fm);
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    check("b2b_strobes", strobe_cnt, 18);
    check("b2b_loads", load_cnt, 2);
    check("b2b_data0", (load_data.size() > 0) ? int'(load_data[0]) : -1, 8'h3C);
    check("b2b_data1", (load_data.size() > 1) ? int'(load_data[1]) : -1, 8'hC3);

    // reset after the 4th strobe aborts the frame
    clear_mon();
    got4 = 0;
    fork
      send_frame(8'hF5, 1'b1, m, fm);
      begin
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (strobe_cnt >= 4) begin
            got4 = 1;
            break;
          end
        end
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
      end
    join
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_reached_4th", got4, 1);
    check("midrst_strobes", strobe_cnt, 4);
    check("midrst_loads", load_cnt, 0);
    check("midrst_busy", busy, 0);

    clear_mon();
    send_frame(8'h96, 1'b1, m, fm);
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    check_frame("post_rst", m);
    check("post_rst_loads", load_cnt, 1);
    check("post_rst_data", (load_data.size() > 0) ? int'(load_data[0]) : -1, 8'h96);
    check("post_rst_ferr", framing_error, 0);

    check("strobe_load_overlap", overlap_cnt, 0);
    check("sync_two_flop_delay", sync_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
